float_to_fixed_conv: RTL and testbench
======================================

// Module: float_to_fixed_conv
// PURPOSE
//  Iterative IEEE-754-style float -> signed two's-complement fixed-point converter with its own datapath and control FSM.
//  Generalised successor of the single-precision exponent-normalising converter: exponent/mantissa/output widths,
//  fraction bits and shift-per-cycle are parametrised; adds overflow, Inf/NaN and zero/denormal handling.
//  Sits between the float front end and the fixed-point arithmetic units; Begin/Ack handshake with the sequencer.
// PARAMETERS
//  EW     8   exponent width; bias = 2**(EW-1)-1
//  MW     23  stored mantissa width (hidden 1 implied)
//  OUT_W  32  fixed output width, signed; constraint OUT_W >= MW+2
//  FRAC   16  fraction bits of the fixed output
//  STEP   4   max shift distance per SHIFT cycle (1..8)
// PORTS
//  CLK        in   1         system clock, rising edge
//  RST_N      in   1         asynchronous reset, active-low
//  RST_FSM    in   1         synchronous restart: DONE -> IDLE
//  BEGIN_FSM  in   1         start conversion; sampled only in IDLE
//  FLOAT_IN   in   EW+MW+1   {sign, exp, mant}; latched in IDLE when BEGIN_FSM=1
//  FIXED_OUT  out  OUT_W     result, FRAC fraction bits, registered
//  ACK        out  1         conversion done; high throughout DONE
//  BUSY       out  1         high in LOAD/SHIFT/NEG
//  OVF        out  1         |result| >= 2**(OUT_W-1), or Inf/NaN input; valid while ACK=1
// BEHAVIOUR
//  Reset (RST_N=0, any state, mid-operation included): state=IDLE, FIXED_OUT=0, ACK=0, BUSY=0, OVF=0, internal regs 0.
//  States: IDLE, LOAD, SHIFT, NEG, DONE.
//  IDLE: BEGIN_FSM=1 -> latch FLOAT_IN, clear OVF, go LOAD. FIXED_OUT retains the previous result.
//  LOAD: ACC <= {1,mant} (exp!=0), else ACC <= 0. SH = (exp - bias) + FRAC - MW, signed, width EW+2 minimum.
//    exp==0 (zero/denormal): result 0, go NEG. exp==all-ones (Inf/NaN): OVF<=1, go NEG.
//    SH==0 -> NEG; otherwise -> SHIFT with CNT = |SH| and DIR = (SH>0 ? left : right).
//  SHIFT: each cycle shift ACC by d = min(CNT, STEP) in DIR; CNT -= d.
//    Left: ACC is OUT_W+STEP bits. After the shift, any bit at index >= OUT_W-1 set -> OVF<=1, go NEG at once.
//    Right: bits shifted out are discarded (truncation toward zero). ACC==0 -> go NEG at once.
//    CNT==0 after the shift -> NEG.
//  NEG: FIXED_OUT <= OVF ? ovf_value : (sign ? -ACC[OUT_W-1:0] : ACC[OUT_W-1:0]). Go DONE.
//  DONE: ACK=1. Hold FIXED_OUT and OVF. RST_FSM=1 -> IDLE on the next edge. BEGIN_FSM is ignored here.
//  BEGIN_FSM is ignored outside IDLE; FLOAT_IN may change freely once latched.
//  Latency: BEGIN_FSM sampled at edge t0; ACK rises after edge t0+2+k, where k = number of SHIFT cycles
//    (k <= ceil(|SH|/STEP); fewer on early stop; 0 for zero/Inf/NaN/SH==0).
//  RST_FSM has no effect outside DONE.
//  -0.0 -> 0x0. Result magnitude 2**(OUT_W-1) counts as overflow for both signs (min negative is never produced).
// CONFIGURATION
//  FIXED_SAT_EN defined: ovf_value = sign ? -(2**(OUT_W-1)-1) : 2**(OUT_W-1)-1.
//    Symmetric saturation: 0x7FFFFFFF / 0x80000001 at defaults.
//  FIXED_SAT_EN undefined: ovf_value = 0. OVF is the only overflow indication.
//  OVF, ACK and latency are identical in both builds.
// TESTING (defaults; S = FIXED_SAT_EN defined)
//  1. 0x3F800000 (1.0) -> FIXED_OUT=0x00010000, OVF=0. SH=-7: k=2, ACK rises 4 cycles after the BEGIN edge.
//  2. 0xC0200000 (-2.5) -> 0xFFFD8000, OVF=0.
//     0x35800000 (2^-20) -> 0x00000000, OVF=0.
//  3. 0x47800000 (65536.0) -> OVF=1; FIXED_OUT=0x7FFFFFFF (S) / 0x00000000 (no S).
//     0xC7800000 -> 0x80000001 (S).
//  4. 0x00000000 and 0x00000001 -> FIXED_OUT=0, OVF=0, ACK 2 cycles after BEGIN.
//     0x7F800000 and 0x7FC00000 -> OVF=1, 0x7FFFFFFF (S).
//  5. BEGIN_FSM pulsed again while BUSY=1 and in DONE -> ignored, result unchanged.
//     RST_FSM in DONE -> IDLE; the next BEGIN converts normally.
//  6. RST_N low during SHIFT -> all outputs 0 at once; after release, IDLE. A new 1.0 conversion -> 0x00010000.

Source files
------------

// File: rtl/float_to_fixed_conv.sv
// float_to_fixed_conv: iterative float -> signed fixed-point converter with a Begin/Ack handshake.
// Define FIXED_SAT_EN to saturate on overflow; otherwise an overflowed result reads as zero.
module float_to_fixed_conv #(
    parameter int EW    = 8,
    parameter int MW    = 23,
    parameter int OUT_W = 32,
    parameter int FRAC  = 16,
    parameter int STEP  = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             RST_FSM,
    input  logic             BEGIN_FSM,
    input  logic [EW+MW:0]   FLOAT_IN,
    output logic [OUT_W-1:0] FIXED_OUT,
    output logic             ACK,
    output logic             BUSY,
    output logic             OVF
);
    localparam int ACC_W = OUT_W + STEP;
    localparam int BIAS  = 2 ** (EW - 1) - 1;

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, NEG, DONE} state_t;

    state_t             state, state_n;
    logic [EW+MW:0]     flt, flt_n;
    logic [ACC_W-1:0]   acc, acc_n, acc_sh;
    logic [31:0]        cnt, cnt_n, d;
    logic               left, left_n, ovf_n;
    logic [OUT_W-1:0]   out_n, mag, ovf_val;
    logic [EW-1:0]      exp_f;
    int                 sh;

    assign exp_f = flt[EW+MW-1:MW];
    assign mag   = acc[OUT_W-1:0];
    assign ACK   = state == DONE;
    assign BUSY  = state == LOAD || state == SHIFT || state == NEG;

`ifdef FIXED_SAT_EN
    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
    assign ovf_val = flt[EW+MW] ? SAT_NEG : SAT_POS;
`else
    assign ovf_val = '0;
`endif

    always_comb begin
        state_n = state;
        flt_n   = flt;
        acc_n   = acc;
        cnt_n   = cnt;
        left_n  = left;
        ovf_n   = OVF;
        out_n   = FIXED_OUT;
        sh      = int'(exp_f) - BIAS + FRAC - MW;
        d       = cnt < 32'(STEP) ? cnt : 32'(STEP);
        acc_sh  = left ? acc << d : acc >> d;
        case (state)
            IDLE: if (BEGIN_FSM) begin
                flt_n   = FLOAT_IN;
                ovf_n   = 1'b0;
                state_n = LOAD;
            end
            LOAD: begin
                acc_n   = exp_f == '0 ? '0 : {{(ACC_W-MW-1){1'b0}}, 1'b1, flt[MW-1:0]};
                cnt_n   = sh < 0 ? 32'(-sh) : 32'(sh);
                left_n  = sh > 0;
                ovf_n   = exp_f == '1;
                state_n = (exp_f == '0 || exp_f == '1 || sh == 0) ? NEG : SHIFT;
            end
            SHIFT: begin
                acc_n = acc_sh;
                cnt_n = cnt - d;
                // any bit reaching the sign position means |result| >= 2**(OUT_W-1)
                if (left && |acc_sh[ACC_W-1:OUT_W-1]) begin
                    ovf_n   = 1'b1;
                    state_n = NEG;
                end else if ((!left && acc_sh == '0) || cnt == d)
                    state_n = NEG;
            end
            NEG: begin
                out_n   = OVF ? ovf_val : flt[EW+MW] ? -mag : mag;
                state_n = DONE;
            end
            DONE: if (RST_FSM) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            flt       <= '0;
            acc       <= '0;
            cnt       <= '0;
            left      <= 1'b0;
            OVF       <= 1'b0;
            FIXED_OUT <= '0;
        end else begin
            state     <= state_n;
            flt       <= flt_n;
            acc       <= acc_n;
            cnt       <= cnt_n;
            left      <= left_n;
            OVF       <= ovf_n;
            FIXED_OUT <= out_n;
        end
    end
endmodule

// File: tb/tb_float_to_fixed_conv.sv
// tb_float_to_fixed_conv: vector table, handshake corner sequences and random floats vs. an arithmetic model.
module tb_float_to_fixed_conv;
`ifdef FIXED_SAT_EN
    localparam logic [31:0] SAT_P = 32'h7FFFFFFF;
    localparam logic [31:0] SAT_N = 32'h80000001;
`else
    localparam logic [31:0] SAT_P = 32'h0;
    localparam logic [31:0] SAT_N = 32'h0;
`endif

    logic        CLK = 0, RST_N = 0, RST_FSM = 0, BEGIN_FSM = 0;
    logic [31:0] FLOAT_IN = 0, FIXED_OUT;
    logic        ACK, BUSY, OVF;
    int          total = 0, bad = 0;

    float_to_fixed_conv dut (
        .CLK(CLK), .RST_N(RST_N), .RST_FSM(RST_FSM), .BEGIN_FSM(BEGIN_FSM),
        .FLOAT_IN(FLOAT_IN), .FIXED_OUT(FIXED_OUT), .ACK(ACK), .BUSY(BUSY), .OVF(OVF)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] f;
        logic [31:0] o;
        logic        v;
        int          lat;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        while (!ACK && lat < 300) begin
            @(posedge CLK); #1;
            lat++;
        end
        if (!ACK) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got no ACK want ACK within 300 cycles");
        end
    endtask

    // starts in IDLE #1 after an edge; returns in IDLE #1 after an edge
    task automatic run(input logic [31:0] f, output logic [31:0] o, output logic v, output int lat);
        FLOAT_IN  = f;
        BEGIN_FSM = 1;
        @(posedge CLK); #1;
        BEGIN_FSM = 0;
        FLOAT_IN  = $urandom;
        wait_ack(lat);
        o = FIXED_OUT;
        v = OVF;
        RST_FSM = 1;
        @(posedge CLK); #1;
        RST_FSM = 0;
    endtask

    function automatic void model(input logic [31:0] f, output logic [31:0] o, output logic v, output int sh);
        int     e = int'(f[30:23]);
        longint m = longint'({1'b1, f[22:0]});
        longint mag = 0;
        sh = e - 127 + 16 - 23;
        v  = 0;
        if (e == 255) v = 1;
        else if (e != 0) begin
            if (sh >= 0) begin
                v   = sh >= 32 || (m << sh) >= 64'h8000_0000;
                mag = v ? 0 : m << sh;
            end else
                mag = -sh >= 32 ? 0 : m >> (-sh);
        end
        o = v ? (f[31] ? SAT_N : SAT_P) : (f[31] ? -mag[31:0] : mag[31:0]);
    endfunction

    initial begin
        logic [31:0] o, mo, f;
        logic        v, mv;
        int          lat, sh, bound;
        tbl = '{
            '{32'h3F800000, 32'h00010000, 1'b0, 4},
            '{32'h3FC00000, 32'h00018000, 1'b0, 4},
            '{32'hC0200000, 32'hFFFD8000, 1'b0, 4},
            '{32'h35800000, 32'h00000000, 1'b0, 8},
            '{32'h47800000, SAT_P,        1'b1, 4},
            '{32'hC7800000, SAT_N,        1'b1, 4},
            '{32'h00000000, 32'h00000000, 1'b0, 2},
            '{32'h00000001, 32'h00000000, 1'b0, 2},
            '{32'h80000000, 32'h00000000, 1'b0, 2},
            '{32'h7F800000, SAT_P,        1'b1, 2},
            '{32'h7FC00000, SAT_P,        1'b1, 2},
            '{32'hFF800000, SAT_N,        1'b1, 2},
            '{32'h46800000, 32'h40000000, 1'b0, 4},
            '{32'h47000000, SAT_P,        1'b1, 4},
            '{32'h46FFFFFF, 32'h7FFFFF80, 1'b0, 4},
            '{32'hC6FFFFFF, 32'h80000080, 1'b0, 4},
            '{32'h43000000, 32'h00800000, 1'b0, 2},
            '{32'h37800000, 32'h00000001, 1'b0, 8},
            '{32'h37000000, 32'h00000000, 1'b0, 8},
            '{32'h7F000000, SAT_P,        1'b1, 4}
        };

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out", FIXED_OUT, 0);
        chk("rst_ack", 32'(ACK), 0);
        chk("rst_busy", 32'(BUSY), 0);
        chk("rst_ovf", 32'(OVF), 0);
        RST_N = 1;
        @(posedge CLK); #1;

        foreach (tbl[i]) begin
            run(tbl[i].f, o, v, lat);
            chk($sformatf("tbl%0d_out", i), o, tbl[i].o);
            chk($sformatf("tbl%0d_ovf", i), 32'(v), 32'(tbl[i].v));
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
        end

        // BEGIN and RST_FSM while busy, BEGIN while done, restart from DONE
        FLOAT_IN  = 32'hC0200000;
        BEGIN_FSM = 1;
        @(posedge CLK); #1;
        chk("seq_busy_load", 32'(BUSY), 1);
        FLOAT_IN = 32'h3F800000;
        RST_FSM  = 1;
        @(posedge CLK); #1;
        RST_FSM   = 0;
        BEGIN_FSM = 0;
        chk("seq_busy_shift", 32'(BUSY), 1);
        chk("seq_ack_early", 32'(ACK), 0);
        wait_ack(lat);
        chk("seq_lat", 32'(lat), 3);
        chk("seq_out", FIXED_OUT, 32'hFFFD8000);
        BEGIN_FSM = 1;
        FLOAT_IN  = 32'h3F800000;
        repeat (3) @(posedge CLK);
        #1;
        BEGIN_FSM = 0;
        chk("done_hold_ack", 32'(ACK), 1);
        chk("done_hold_busy", 32'(BUSY), 0);
        chk("done_hold_out", FIXED_OUT, 32'hFFFD8000);
        RST_FSM = 1;
        @(posedge CLK); #1;
        RST_FSM = 0;
        chk("idle_ack", 32'(ACK), 0);
        chk("idle_busy", 32'(BUSY), 0);
        chk("idle_keep_out", FIXED_OUT, 32'hFFFD8000);
        run(32'h3F800000, o, v, lat);
        chk("restart_out", o, 32'h00010000);
        chk("restart_lat", 32'(lat), 4);

        // async reset in the middle of SHIFT
        FLOAT_IN  = 32'h35800000;
        BEGIN_FSM = 1;
        @(posedge CLK); #1;
        BEGIN_FSM = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("pre_rst_busy", 32'(BUSY), 1);
        RST_N = 0;
        #1;
        chk("mid_rst_out", FIXED_OUT, 0);
        chk("mid_rst_ack", 32'(ACK), 0);
        chk("mid_rst_busy", 32'(BUSY), 0);
        chk("mid_rst_ovf", 32'(OVF), 0);
        @(posedge CLK); #1;
        RST_N = 1;
        @(posedge CLK); #1;
        chk("post_rst_busy", 32'(BUSY), 0);
        run(32'h3F800000, o, v, lat);
        chk("post_rst_out", o, 32'h00010000);
        chk("post_rst_ovf", 32'(v), 0);

        for (int n = 0; n < 150; n++) begin
            f = $urandom;
            if ($urandom_range(0, 3) != 0)
                f[30:23] = 8'($urandom_range(100, 160));
            model(f, mo, mv, sh);
            run(f, o, v, lat);
            chk($sformatf("rnd_out %h", f), o, mo);
            chk($sformatf("rnd_ovf %h", f), 32'(v), 32'(mv));
            bound = 2 + ((sh < 0 ? -sh : sh) + 3) / 4;
            if (f[30:23] == 8'h00 || f[30:23] == 8'hFF || sh == 0)
                chk($sformatf("rnd_lat %h", f), 32'(lat), 2);
            else
                chk($sformatf("rnd_lat_rng %h lat %0d", f, lat), 32'(lat >= 3 && lat <= bound), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
